// File: rtl/board_collision.sv
// rtl/board_collision.sv - playfield occupancy, collision, line clear and respawn stage
// Holds a ROWS x COLS occupancy grid, locks landed pieces, clears full rows and gates respawn.
module board_collision #(
  parameter int          CELL      = 20,
  parameter int          COLS      = 24,
  parameter int          ROWS      = 24,
  parameter int          SPAWN_X   = 280,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       iVGA_CLK,
  input  logic       reset,
  input  logic [9:0] ref_x,
  input  logic [9:0] ref_y,
  input  logic [2:0] shape,
  input  logic       start_over,
  output logic       stop,
  output logic       hit,
  output logic       change_shape,
  output logic [2:0] next_shape,
  output logic [7:0] lines_cleared,
  output logic       game_over
);
  localparam int PW = $clog2(ROWS);

  typedef enum logic [2:0] {S_PLAY, S_LOCK, S_SCAN, S_RESPAWN, S_OVER} state_t;
  state_t r_state, w_state_next;

  logic [COLS-1:0] r_grid [ROWS];
  logic [COLS-1:0] r_lock_cols;
  logic [ROWS-1:0] r_lock_rows;
  logic [PW-1:0]   r_ptr;
  logic [7:0]      r_lfsr;
  logic            r_stop, r_hit, r_change, r_over;
  logic [2:0]      r_next;
  logic [7:0]      r_lines;

  logic [9:0]      w_col0, w_row0, w_rem;
  logic [2:0]      w_w, w_h, w_cand;
  logic [COLS-1:0] w_cols, w_side, w_spawn_cols;
  logic [ROWS-1:0] w_rows, w_spawn_rows;
  logic            w_land, w_hit, w_spawn_block, w_row_full, w_at_spawn;

  function automatic logic [2:0] shape_w(input logic [2:0] s);
    return (s == 3'd1) ? 3'd4 : (s == 3'd2) ? 3'd1 : 3'd2;
  endfunction

  function automatic logic [2:0] shape_h(input logic [2:0] s);
    return (s == 3'd1) ? 3'd1 : (s == 3'd2) ? 3'd4 : 3'd2;
  endfunction

  // Bits outside the grid simply never appear in the mask, so off-grid cells read and write as empty.
  function automatic logic [COLS-1:0] col_span(input int lo, input int n);
    logic [COLS-1:0] m;
    m = '0;
    for (int i = 0; i < COLS; i++)
      if (i >= lo && i < lo + n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [ROWS-1:0] row_span(input int lo, input int n);
    logic [ROWS-1:0] m;
    m = '0;
    for (int i = 0; i < ROWS; i++)
      if (i >= lo && i < lo + n) m[i] = 1'b1;
    return m;
  endfunction

  assign w_cand = (r_lfsr[1:0] == 2'd1) ? 3'd1 : (r_lfsr[1:0] == 2'd2) ? 3'd2 : 3'd3;
  assign w_at_spawn = (ref_y == 10'd0) && (ref_x == 10'(SPAWN_X));

  always_comb begin
    w_col0 = ref_x / 10'(CELL);
    w_row0 = ref_y / 10'(CELL);
    w_rem  = ref_y % 10'(CELL);
    w_w    = shape_w(shape);
    w_h    = shape_h(shape);
    w_cols = col_span(int'(w_col0), int'(w_w));
    w_rows = row_span(int'(w_row0), int'(w_h) + ((w_rem != 10'd0) ? 1 : 0));
    w_side = col_span(int'(w_col0) - 1, 1) | col_span(int'(w_col0) + int'(w_w), 1);
    w_spawn_cols = col_span(SPAWN_X / CELL, int'(shape_w(r_next)));
    w_spawn_rows = row_span(0, int'(shape_h(r_next)));
    w_land        = 1'b0;
    w_hit         = 1'b0;
    w_spawn_block = 1'b0;
    w_row_full    = 1'b0;
    if (w_rem == 10'd0 && int'(w_row0) + int'(w_h) >= ROWS) w_land = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      if (w_rem == 10'd0 && r == int'(w_row0) + int'(w_h) && (r_grid[r] & w_cols) != '0)
        w_land = 1'b1;
      if (w_rows[r] && (r_grid[r] & w_side) != '0) w_hit = 1'b1;
      if (w_spawn_rows[r] && (r_grid[r] & w_spawn_cols) != '0) w_spawn_block = 1'b1;
      if (PW'(r) == r_ptr && (&r_grid[r])) w_row_full = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (start_over) begin
      w_state_next = S_RESPAWN;
    end else begin
      case (r_state)
        S_PLAY:    if (w_land) w_state_next = S_LOCK;
        S_LOCK:    w_state_next = S_SCAN;
        S_SCAN:    if (!w_row_full && r_ptr == '0) w_state_next = S_RESPAWN;
        S_RESPAWN: if (w_at_spawn) w_state_next = w_spawn_block ? S_OVER : S_PLAY;
        S_OVER:    w_state_next = S_OVER;
        default:   w_state_next = S_PLAY;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (reset) r_state <= S_PLAY;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) r_grid[r] <= '0;
      r_lock_cols <= '0;
      r_lock_rows <= '0;
      r_ptr       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_stop      <= 1'b0;
      r_hit       <= 1'b0;
      r_change    <= 1'b0;
      r_next      <= 3'd3;
      r_lines     <= 8'd0;
      r_over      <= 1'b0;
    end else begin
      r_lfsr   <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_stop   <= (w_state_next != S_PLAY);
      r_over   <= (w_state_next == S_OVER);
      r_hit    <= (r_state == S_PLAY) && (w_state_next == S_PLAY) && w_hit;
      r_change <= 1'b0;
      if (start_over) begin
        for (int r = 0; r < ROWS; r++) r_grid[r] <= '0;
        r_lines <= 8'd0;
      end else begin
        case (r_state)
          // Footprint is captured at landing since the controller recentres the piece once stop rises.
          S_PLAY: if (w_land) begin
            r_lock_cols <= w_cols;
            r_lock_rows <= w_rows;
          end
          S_LOCK: begin
            for (int r = 0; r < ROWS; r++)
              if (r_lock_rows[r]) r_grid[r] <= r_grid[r] | r_lock_cols;
            r_ptr <= PW'(ROWS - 1);
          end
          S_SCAN: begin
            if (w_row_full) begin
              for (int r = 1; r < ROWS; r++)
                if (PW'(r) <= r_ptr) r_grid[r] <= r_grid[r-1];
              r_grid[0] <= '0;
              r_lines   <= r_lines + 8'd1;
            end else if (r_ptr != '0) begin
              r_ptr <= r_ptr - PW'(1);
            end
          end
          S_RESPAWN: if (w_at_spawn && !w_spawn_block) begin
            r_change <= 1'b1;
            r_next   <= w_cand;
          end
          default: ;
        endcase
      end
    end
  end

  assign stop          = r_stop;
  assign hit           = r_hit;
  assign change_shape  = r_change;
  assign next_shape    = r_next;
  assign lines_cleared = r_lines;
  assign game_over     = r_over;
endmodule

// File: tb/tb_board_collision.sv
// tb/tb_board_collision.sv - directed and randomized checks of board_collision against a playfield model
module tb_board_collision;
  localparam int CELL = 20, COLS = 24, ROWS = 24, SPAWN_X = 280;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] ref_x = 10'(SPAWN_X);
  logic [9:0] ref_y = 10'd0;
  logic [2:0] shape = 3'd3;
  logic       start_over = 1'b0;
  logic       stop, hit, change_shape, game_over;
  logic [2:0] next_shape;
  logic [7:0] lines_cleared;

  always #5 clk = ~clk;

  board_collision dut (
    .iVGA_CLK(clk), .reset(reset), .ref_x(ref_x), .ref_y(ref_y), .shape(shape),
    .start_over(start_over), .stop(stop), .hit(hit), .change_shape(change_shape),
    .next_shape(next_shape), .lines_cleared(lines_cleared), .game_over(game_over)
  );

  int checks = 0;
  int failures = 0;

  bit         m_grid [ROWS][COLS];
  int         m_lines;
  logic [2:0] m_next;
  bit         m_over;
  logic [7:0] m_lfsr, m_prev;

  always @(posedge clk) begin
    m_prev <= m_lfsr;
    m_lfsr <= reset ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dim_w(input int s);
    return (s == 1) ? 4 : (s == 2) ? 1 : 2;
  endfunction

  function automatic int dim_h(input int s);
    return (s == 1) ? 1 : (s == 2) ? 4 : 2;
  endfunction

  function automatic logic [2:0] cand(input logic [7:0] l);
    return (l[1:0] == 2'd1) ? 3'd1 : (l[1:0] == 2'd2) ? 3'd2 : 3'd3;
  endfunction

  function automatic bit m_land(input int s, input int col, input int row);
    int h = dim_h(s);
    if (row + h >= ROWS) return 1'b1;
    for (int c = col; c < col + dim_w(s); c++)
      if (c < COLS && m_grid[row+h][c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hit(input int s, input int x, input int y);
    int col0 = x / CELL;
    int row0 = y / CELL;
    int w = dim_w(s);
    int h = dim_h(s) + (((y % CELL) != 0) ? 1 : 0);
    for (int r = row0; r < row0 + h && r < ROWS; r++) begin
      if (col0 >= 1 && m_grid[r][col0-1]) return 1'b1;
      if (col0 + w < COLS && m_grid[r][col0+w]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void m_lock(input int s, input int x, input int y);
    for (int r = y / CELL; r < y / CELL + dim_h(s); r++)
      for (int c = x / CELL; c < x / CELL + dim_w(s); c++)
        if (r < ROWS && c < COLS) m_grid[r][c] = 1'b1;
  endfunction

  function automatic int m_clear();
    bit ng [ROWS][COLS];
    int dst = ROWS - 1;
    int n = 0;
    bit full;
    ng = '{default: '0};
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (!m_grid[r][c]) full = 1'b0;
      if (full) n++;
      else begin
        for (int c = 0; c < COLS; c++) ng[dst][c] = m_grid[r][c];
        dst--;
      end
    end
    m_grid = ng;
    return n;
  endfunction

  function automatic bit m_spawn_blocked();
    for (int r = 0; r < dim_h(int'(m_next)); r++)
      for (int c = SPAWN_X / CELL; c < SPAWN_X / CELL + dim_w(int'(m_next)) && c < COLS; c++)
        if (m_grid[r][c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [COLS-1:0] m_row(input int r);
    logic [COLS-1:0] v;
    for (int c = 0; c < COLS; c++) v[c] = m_grid[r][c];
    return v;
  endfunction

  task automatic check_grid(input string tag);
    for (int r = 0; r < ROWS; r++)
      check($sformatf("%s_row%0d", tag, r), 32'(dut.r_grid[r]), 32'(m_row(r)));
  endtask

  task automatic do_reset();
    reset = 1'b1; start_over = 1'b0; shape = 3'd3;
    ref_x = 10'(SPAWN_X); ref_y = 10'd0;
    tick(); tick();
    reset = 1'b0;
    m_grid = '{default: '0};
    m_lines = 0; m_next = 3'd3; m_over = 1'b0;
  endtask

  // Waits out lock/scan (optionally with the piece held away from spawn) and checks the release or game over.
  task automatic finish_drop(input int hold, input int clr);
    int n, exp_lat;
    bit bad;
    bad = 1'b0;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        if (stop !== 1'b1 || change_shape !== 1'b0 || game_over !== 1'b0) bad = 1'b1;
      end
      check("hold_stop", 32'(bad), 32'd0);
      exp_lat = 1;
    end else begin
      exp_lat = 26 + clr;
    end
    ref_x = 10'(SPAWN_X); ref_y = 10'd0;
    n = 0; bad = 1'b0;
    while (n < 300) begin
      tick(); n++;
      if (!(next_shape inside {3'd1, 3'd2, 3'd3})) bad = 1'b1;
      if (change_shape === 1'b1 || game_over === 1'b1) break;
      if (stop !== 1'b1) bad = 1'b1;
    end
    check("respawn_latency", 32'(n), 32'(exp_lat));
    check("wait_stop_shape", 32'(bad), 32'd0);
    m_over = m_spawn_blocked();
    check("game_over", 32'(game_over), 32'(m_over));
    check("change_shape", 32'(change_shape), 32'(!m_over));
    check("lines", 32'(lines_cleared), 32'(m_lines));
    check_grid("grid");
    if (!m_over) begin
      m_next = cand(m_prev);
      check("next_shape", 32'(next_shape), 32'(m_next));
      check("stop_released", 32'(stop), 32'd0);
    end else begin
      check("stop_over", 32'(stop), 32'd1);
    end
  endtask

  task automatic drop(input int s, input int x, input int y, input int hold);
    int clr;
    shape = 3'(s); ref_x = 10'(x); ref_y = 10'(y);
    tick();
    check("land_stop", 32'(stop), 32'd1);
    check("land_hit", 32'(hit), 32'd0);
    check("land_pulse", 32'(change_shape), 32'd0);
    m_lock(s, x, y);
    clr = m_clear();
    m_lines = (m_lines + clr) % 256;
    finish_drop(hold, clr);
  endtask

  task automatic restart();
    start_over = 1'b1;
    tick();
    start_over = 1'b0;
    m_grid = '{default: '0};
    m_lines = 0; m_over = 1'b0;
    check("so_stop", 32'(stop), 32'd1);
    check("so_over", 32'(game_over), 32'd0);
    check("so_lines", 32'(lines_cleared), 32'd0);
    check("so_pulse", 32'(change_shape), 32'd0);
    check_grid("so_grid");
    ref_x = 10'(SPAWN_X); ref_y = 10'd0;
    tick();
    check("so_release", 32'(change_shape), 32'd1);
    m_next = cand(m_prev);
    check("so_next", 32'(next_shape), 32'(m_next));
  endtask

  initial begin
    bit bad;

    do_reset();
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_pulse", 32'(change_shape), 32'd0);
    check("rst_next", 32'(next_shape), 32'd3);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check_grid("rst_grid");

    for (int y = 0; y <= 440; y += 5) begin
      shape = 3'd3; ref_x = 10'd280; ref_y = 10'(y);
      tick();
      check("fall_stop", 32'(stop), 32'(y == 440));
    end
    m_lock(3, 280, 440);
    finish_drop(40, m_clear());
    check("sq_row22", 32'(dut.r_grid[22]), 32'h00C000);
    check("sq_row23", 32'(dut.r_grid[23]), 32'h00C000);
    tick();
    check("pulse_one_cycle", 32'(change_shape), 32'd0);

    do_reset();
    for (int x = 0; x <= 320; x += 80) drop(1, x, 460, 0);
    drop(1, 400, 460, 0);
    check("one_clear_lines", 32'(lines_cleared), 32'd1);
    check("one_clear_row23", 32'(dut.r_grid[23]), 32'd0);

    do_reset();
    for (int x = 0; x <= 440; x += 40) drop(3, x, 440, 0);
    check("two_clear_lines", 32'(lines_cleared), 32'd2);
    check("two_clear_row22", 32'(dut.r_grid[22]), 32'd0);

    do_reset();
    drop(2, 260, 400, 0);
    shape = 3'd2; ref_x = 10'd280; ref_y = 10'd390;
    tick();
    check("hit_left", 32'(hit), 32'd1);
    check("hit_left_model", 32'(hit), 32'(m_hit(2, 280, 390)));
    ref_x = 10'd320;
    tick();
    check("hit_clear", 32'(hit), 32'd0);
    ref_x = 10'd240;
    tick();
    check("hit_right", 32'(hit), 32'd1);
    drop(2, 240, 400, 0);

    do_reset();
    for (int y = 400; y >= 0; y -= 80) drop(2, 280, y, 0);
    check("col_full_over", 32'(game_over), 32'd1);
    restart();

    shape = 3'd3; ref_x = 10'd280; ref_y = 10'd440; start_over = 1'b1;
    tick();
    start_over = 1'b0;
    m_grid = '{default: '0};
    check("race_stop", 32'(stop), 32'd1);
    check("race_lines", 32'(lines_cleared), 32'd0);
    bad = 1'b0;
    repeat (40) begin
      tick();
      if (stop !== 1'b1 || change_shape !== 1'b0) bad = 1'b1;
    end
    check("race_respawn_hold", 32'(bad), 32'd0);
    check_grid("race_grid");
    ref_x = 10'(SPAWN_X); ref_y = 10'd0;
    tick();
    check("race_release", 32'(change_shape), 32'd1);
    m_next = cand(m_prev);

    do_reset();
    for (int i = 0; i < 80; i++) begin
      int s, col, x, r0;
      s   = int'($urandom_range(0, 7));
      col = int'($urandom_range(0, COLS - dim_w(s)));
      x   = col * CELL + int'($urandom_range(0, CELL - 1));
      r0  = 0;
      while (!m_land(s, col, r0)) r0++;
      if (r0 > 0) begin
        shape = 3'(s); ref_x = 10'(x); ref_y = 10'(r0 * CELL - 10);
        tick();
        check("rand_hit", 32'(hit), 32'(m_hit(s, x, r0 * CELL - 10)));
        check("rand_no_land", 32'(stop), 32'd0);
        check("rand_pulse", 32'(change_shape), 32'd0);
      end
      drop(s, x, r0 * CELL, ($urandom_range(0, 4) == 0) ? 40 : 0);
      if (m_over) restart();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/board_collision.md
Name: board_collision

Overview:
- Playfield occupancy and collision stage feeding the falling-piece movement controller.
- Consumes the piece reference position (ref_x, ref_y), the active shape code and the start_over request.
- Produces the stop and hit flags the controller uses to gate motion, plus a next-shape code and score/game-over status.
- Keeps a 24x24 grid of 20-pixel cells, locks landed pieces into it, clears full rows and manages respawn.

Parameters:
- CELL, 20, cell size in pixels
- COLS, 24, grid columns (480 px / CELL)
- ROWS, 24, grid rows (480 px / CELL)
- SPAWN_X, 280, controller spawn x in pixels (column 14)
- LFSR_SEED, 8'hA5, shape-generator seed; must be nonzero

Ports:
- iVGA_CLK  in  1  system clock, same clock as the movement controller
- reset  in  1  synchronous, active-high reset
- ref_x  in  10  piece top-left x in pixels
- ref_y  in  10  piece top-left y in pixels
- shape  in  3  1 = 4x1 horizontal, 2 = 1x4 vertical, any other value = 2x2 square
- start_over  in  1  controller restart request, level
- stop  out  1  piece landed or respawn pending; controller recentres piece while high
- hit  out  1  occupied cell directly left or right of the footprint
- change_shape  out  1  one-cycle pulse when a new piece is released
- next_shape  out  3  shape code for the next piece, always in {1,2,3}
- lines_cleared  out  8  count of cleared rows, wraps modulo 256
- game_over  out  1  spawn area is blocked

Behaviour:
- Reset (synchronous, active-high):
  - grid all 0, state PLAY.
  - stop=0, hit=0, change_shape=0, next_shape=3, lines_cleared=0, game_over=0.
  - LFSR loaded with LFSR_SEED.
- Footprint:
  - col0 = ref_x/CELL, row0 = ref_y/CELL (integer division).
  - Width and height in cells: 4x1 for shape 1, 1x4 for shape 2, 2x2 otherwise.
  - When ref_y%CELL != 0, the footprint spans one extra row.
  - Cells outside the grid are treated as empty and never written.
- Landing condition:
  - Applies only when ref_y%CELL == 0.
  - The row below the footprint is ROWS, or any grid cell directly below a footprint cell is set.
- hit (registered, recomputed every cycle in PLAY):
  - Set when column col0-1 or column col0+width holds a set cell in any row the footprint spans.
  - Held at 0 outside PLAY.
- LFSR:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4; advances every cycle.
  - Candidate shape = 1 if lfsr[1:0]==1, 2 if ==2, else 3.
- FSM (one transition per cycle):
  - PLAY: stop=0. If the landing condition holds, set stop=1 on the next cycle and go to LOCK.
  - LOCK: OR all footprint cells into the grid in one cycle; set row pointer to ROWS-1; go to SCAN.
  - SCAN, when row[ptr] is all ones: shift rows ptr-1..0 down by one and zero row 0, all in one cycle; increment lines_cleared; ptr stays unchanged so the shifted row is rechecked.
  - SCAN, otherwise: if ptr==0 go to RESPAWN, else decrement ptr.
  - RESPAWN: stop held 1. Wait until ref_y==0 and ref_x==SPAWN_X.
    - If the spawn footprint (shape = next_shape) overlaps the grid: go to OVER.
    - Otherwise: pulse change_shape for one cycle, latch next_shape from the LFSR candidate, go to PLAY.
  - OVER: stop=1, game_over=1. Leaves only via start_over.
- start_over=1, in any state and taking priority over all transitions:
  - Clear the grid, lines_cleared and game_over.
  - Drop change_shape; go to RESPAWN (stop=1).
- reset takes priority over start_over.
- The grid keeps no state outside the FSM; all outputs are registered.
- A landing in PLAY and a start_over in the same cycle: start_over wins and the piece is not locked.

Test Plan:
- Reset, then shape=3 with ref_x=280 falling from ref_y=0 in steps of 5 -> stop rises only after ref_y=440 is applied; row 22-23 columns 14-15 are set; stop stays 1 until ref=(280,0); then change_shape pulses exactly one cycle.
- Preload row 23 columns 0-19 as set; drop shape 1 at ref_x=400 to ref_y=460 -> exactly one SCAN shift; lines_cleared=1; row 23 now holds the contents of the former row 22.
- Two full rows (22, 23) at lock -> lines_cleared=2; rows shifted by 2; SCAN ends at ptr=0.
- Set cell (col 13, row 5); place shape 2 at ref_x=280, ref_y=80 -> hit=1 one cycle later; move to ref_x=320 -> hit=0.
- Fill column 14 to row 1, then respawn -> game_over=1, stop=1, no change_shape; assert start_over one cycle -> grid empty, lines_cleared=0, game_over=0.
- Hold the landing condition and start_over in the same cycle -> no cells written, state RESPAWN; over 1000 cycles next_shape never leaves {1,2,3}.
